// File: rtl/ss_seq_engine_pkg.sv
// Shared types and defaults for the save-state sequencer.
package ss_seq_engine_pkg;

  localparam int unsigned SS_LEN_DEF  = 128;
  localparam int unsigned RD_WAIT_DEF = 2;
  localparam int unsigned M2_HALF_DEF = 2;

  typedef enum logic [3:0] {
    StIdle,
    StSvSet,
    StSvWait,
    StSvPush,
    StLdChk,
    StLdGet,
    StLdSet,
    StLdFall,
    StLdRise,
    StFin
  } ss_state_e;

  // The last slot of every image holds the mapper index.
  function automatic logic [7:0] idx_slot(input int unsigned len);
    return 8'(len - 1);
  endfunction

endpackage

// File: rtl/ss_m2_gen.sv
// Substitute m2 generator: M2_HALF cycles high, then M2_HALF cycles low, while enabled.
module ss_m2_gen #(
  parameter int unsigned M2_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic m2,
  output logic fall_done,
  output logic rise_done
);

  localparam int unsigned CW = (M2_HALF > 1) ? $clog2(M2_HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          low_q, low_d;
  logic          last;

  always_comb begin
    last  = (cnt_q == CW'(M2_HALF - 1));
    cnt_d = cnt_q;
    low_d = low_q;
    if (!en) begin
      cnt_d = '0;
      low_d = 1'b0;
    end else if (last) begin
      cnt_d = '0;
      low_d = ~low_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    m2        = ~low_q;
    fall_done = en & last & ~low_q;
    rise_done = en & last & low_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      low_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      low_q <= low_d;
    end
  end

endmodule

// File: rtl/ss_seq_engine.sv
// Save-state sequencer: streams mapper registers out to the host, or replays a
// host image into the mapper after checking that its map_idx matches.
module ss_seq_engine
  import ss_seq_engine_pkg::*;
#(
  parameter int unsigned SS_LEN  = SS_LEN_DEF,
  parameter int unsigned RD_WAIT = RD_WAIT_DEF,
  parameter int unsigned M2_HALF = M2_HALF_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_save,
  input  logic       start_load,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] sv_dat,
  output logic       sv_valid,
  input  logic       sv_ready,
  input  logic [7:0] ld_dat,
  input  logic       ld_valid,
  output logic       ld_ready,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  output logic       ss_m2,
  input  logic [7:0] ss_rdat
);

  localparam int unsigned WW        = $clog2(RD_WAIT + 1);
  localparam logic [7:0]  LAST_SLOT = idx_slot(SS_LEN);
  localparam logic [7:0]  LAST_LD   = 8'(SS_LEN - 2);

  ss_state_e     state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [7:0]    sv_dat_q, sv_dat_d;
  logic [7:0]    live_idx_q, live_idx_d;
  logic [7:0]    wdat_q, wdat_d;
  logic          err_q, err_d;
  logic          m2_en, fall_done, rise_done;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    sv_dat_d   = sv_dat_q;
    live_idx_d = live_idx_q;
    wdat_d     = wdat_q;
    err_d      = 1'b0;
    ld_ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        wait_d = '0;
        if (start_save)      state_d = StSvSet;
        else if (start_load) state_d = StLdChk;
      end
      StSvSet: begin
        wait_d  = '0;
        state_d = StSvWait;
      end
      StSvWait: begin
        if (wait_q == WW'(RD_WAIT - 1)) begin
          sv_dat_d = ss_rdat;
          state_d  = StSvPush;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      StSvPush: begin
        if (sv_ready) begin
          if (cnt_q == LAST_SLOT) begin
            state_d = StFin;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = StSvSet;
          end
        end
      end
      StLdChk: begin
        // Settle on the index slot, latch the live index, then take the image's index byte.
        if (wait_q != WW'(RD_WAIT)) begin
          wait_d = wait_q + WW'(1);
          if (wait_q == WW'(RD_WAIT - 1)) live_idx_d = ss_rdat;
        end else begin
          ld_ready = ld_valid;
          if (ld_valid) begin
            if (ld_dat != live_idx_q) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StLdGet;
            end
          end
        end
      end
      StLdGet: begin
        ld_ready = ld_valid;
        if (ld_valid) begin
          wdat_d  = ld_dat;
          state_d = StLdSet;
        end
      end
      StLdSet:  if (fall_done) state_d = StLdFall;
      StLdFall: if (rise_done) state_d = StLdRise;
      StLdRise: begin
        cnt_d   = cnt_q + 8'd1;
        state_d = (cnt_q == LAST_LD) ? StFin : StLdGet;
      end
      StFin: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wait_q     <= '0;
      sv_dat_q   <= '0;
      live_idx_q <= '0;
      wdat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      sv_dat_q   <= sv_dat_d;
      live_idx_q <= live_idx_d;
      wdat_q     <= wdat_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    busy     = (state_q != StIdle);
    done     = (state_q == StFin);
    err      = err_q;
    sv_valid = (state_q == StSvPush);
    sv_dat   = sv_dat_q;
    ss_act   = busy && (state_q != StFin);
    m2_en    = (state_q == StLdSet) || (state_q == StLdFall);
    ss_we    = m2_en;
    ss_wdat  = (m2_en || state_q == StLdRise) ? wdat_q : 8'h00;
    if (state_q == StLdChk) ss_addr = LAST_SLOT;
    else if (ss_act)        ss_addr = cnt_q;
    else                    ss_addr = 8'h00;
  end

  ss_m2_gen #(
    .M2_HALF(M2_HALF)
  ) u_m2_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (m2_en),
    .m2       (ss_m2),
    .fall_done(fall_done),
    .rise_done(rise_done)
  );

endmodule

// File: tb/tb_ss_seq_engine.sv
// Directed bench for ss_seq_engine with a 4-slot mapper model.
module tb_ss_seq_engine;

  localparam int unsigned SS_LEN  = 4;
  localparam int unsigned RD_WAIT = 2;
  localparam int unsigned M2_HALF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_save = 1'b0, start_load = 1'b0;
  logic       busy, done, err, sv_valid, ld_ready, ss_act, ss_we, ss_m2;
  logic       sv_ready = 1'b0, ld_valid = 1'b0;
  logic [7:0] sv_dat, ss_addr, ss_wdat, ss_rdat;
  logic [7:0] ld_dat = 8'h00;

  always #5 clk = ~clk;

  ss_seq_engine #(
    .SS_LEN (SS_LEN),
    .RD_WAIT(RD_WAIT),
    .M2_HALF(M2_HALF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_save(start_save),
    .start_load(start_load),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sv_dat    (sv_dat),
    .sv_valid  (sv_valid),
    .sv_ready  (sv_ready),
    .ld_dat    (ld_dat),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ss_act    (ss_act),
    .ss_we     (ss_we),
    .ss_addr   (ss_addr),
    .ss_wdat   (ss_wdat),
    .ss_m2     (ss_m2),
    .ss_rdat   (ss_rdat)
  );

  // Mapper model: registers latch on the falling edge of ss_m2.
  logic [7:0]  mreg [4];
  logic        model_set = 1'b0;
  logic [31:0] model_init = 32'h0;
  int          falls = 0, rises = 0, wr_cnt = 0, we_cycles = 0, done_cnt = 0, err_cnt = 0;
  int          we_run = 0;
  bit          setup_bad = 1'b0, hold_bad = 1'b0;
  logic [7:0]  fall_addr = 8'h00;
  logic [7:0]  svq [$];

  assign ss_rdat = mreg[ss_addr[1:0]];

  always @(negedge ss_m2 or posedge model_set) begin
    if (model_set) begin
      for (int i = 0; i < 4; i++) mreg[i] = model_init[8*i +: 8];
    end else begin
      falls++;
      if (ss_act && ss_we) begin
        mreg[ss_addr[1:0]] = ss_wdat;
        wr_cnt++;
        fall_addr = ss_addr;
        if (we_run < M2_HALF) setup_bad = 1'b1;
      end
    end
  end

  always @(posedge ss_m2) begin
    rises++;
    if (rst_n && ss_act && (we_run < 2 * M2_HALF || ss_addr != fall_addr)) hold_bad = 1'b1;
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (ss_we) begin
      we_cycles++;
      we_run++;
    end else begin
      we_run = 0;
    end
    if (sv_valid && sv_ready) svq.push_back(sv_dat);
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] stream_at(input int base);
    logic [31:0] r = 'x;
    for (int j = 0; j < 4; j++) if (base + j < svq.size()) r[8*j +: 8] = svq[base + j];
    return r;
  endfunction

  function automatic logic [31:0] model_regs();
    return {mreg[3], mreg[2], mreg[1], mreg[0]};
  endfunction

  task automatic set_model(input logic [31:0] v);
    @(negedge clk);
    model_init = v;
    model_set  = 1'b1;
    #1 model_set = 1'b0;
  endtask

  task automatic run_save(output int cyc);
    int bd = done_cnt;
    sv_ready = 1'b1;
    @(negedge clk);
    start_save = 1'b1;
    @(negedge clk);
    start_save = 1'b0;
    for (cyc = 0; cyc < 400; cyc++) begin
      #1;
      if (done_cnt != bd) break;
      @(negedge clk);
    end
  endtask

  // Feeds host bytes (index first); optionally stops at the first ss_m2 fall.
  task automatic run_load(input logic [31:0] host, input bit stop_at_fall, output int cyc);
    int bd = done_cnt;
    int be = err_cnt;
    int k = 0;
    bit take;
    @(negedge clk);
    start_load = 1'b1;
    ld_valid   = 1'b1;
    ld_dat     = host[7:0];
    #1 take = ld_ready;
    for (cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      start_load = 1'b0;
      if (take) begin
        k++;
        if (k >= 4) ld_valid = 1'b0;
        else ld_dat = host[8*k +: 8];
      end
      #1;
      if (done_cnt != bd || err_cnt != be) break;
      if (stop_at_fall && !ss_m2) break;
      take = ld_ready;
    end
    if (!stop_at_fall) ld_valid = 1'b0;
  endtask

  typedef struct packed {
    logic        load;
    logic [31:0] init;
    logic [31:0] host;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cyc, bd, be, bw, bf, br, bq, bad;

    vecs[0] = '{load: 1'b0, init: 32'h39073CA5, host: 32'h0, exp: 32'h39073CA5, exp_err: 1'b0};
    vecs[1] = '{load: 1'b0, init: 32'h1280FF00, host: 32'h0, exp: 32'h1280FF00, exp_err: 1'b0};
    vecs[2] = '{load: 1'b1, init: 32'h39073CA5, host: 32'h33221139, exp: 32'h39332211,
                exp_err: 1'b0};
    vecs[3] = '{load: 1'b1, init: 32'h39332211, host: 32'hCCBBAA40, exp: 32'h39332211,
                exp_err: 1'b1};
    vecs[4] = '{load: 1'b1, init: 32'h5A000000, host: 32'h0302015A, exp: 32'h5A030201,
                exp_err: 1'b0};
    vecs[5] = '{load: 1'b0, init: 32'h5A030201, host: 32'h0, exp: 32'h5A030201, exp_err: 1'b0};

    repeat (3) @(negedge clk);
    check("reset_ctl", {24'h0, busy, done, err, sv_valid, ld_ready, ss_act, ss_we, ss_m2}, 32'h01);
    check("reset_dat", {8'h0, sv_dat, ss_addr, ss_wdat}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ctl", {24'h0, busy, done, err, sv_valid, ld_ready, ss_act, ss_we, ss_m2}, 32'h01);

    for (int i = 0; i < 6; i++) begin
      set_model(vecs[i].init);
      bd = done_cnt; be = err_cnt; bw = we_cycles; bf = falls; br = rises; bq = svq.size();
      if (!vecs[i].load) begin
        run_save(cyc);
        check($sformatf("v%0d_save_len", i), 32'(svq.size() - bq), 32'd4);
        check($sformatf("v%0d_stream", i), stream_at(bq), vecs[i].exp);
        check($sformatf("v%0d_done", i), 32'(done_cnt - bd), 32'd1);
        check($sformatf("v%0d_m2_quiet", i), 32'((rises - br) + (falls - bf)), 32'd0);
      end else begin
        run_load(vecs[i].host, 1'b0, cyc);
        check($sformatf("v%0d_err", i), 32'(err_cnt - be), 32'(vecs[i].exp_err));
        check($sformatf("v%0d_done", i), 32'(done_cnt - bd), 32'(!vecs[i].exp_err));
        check($sformatf("v%0d_falls", i), 32'(falls - bf), vecs[i].exp_err ? 32'd0 : 32'd3);
        check($sformatf("v%0d_regs", i), model_regs(), vecs[i].exp);
        if (vecs[i].exp_err) begin
          check($sformatf("v%0d_no_we", i), 32'(we_cycles - bw), 32'd0);
          check($sformatf("v%0d_err_fast", i), 32'(cyc < RD_WAIT + 3), 32'd1);
          check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
        end
      end
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_busy_end", i), 32'(busy), 32'd0);
    end
    check("we_setup", 32'(setup_bad), 32'd0);
    check("we_hold", 32'(hold_bad), 32'd0);

    // Host stall on byte 1 of a save.
    set_model(32'h39073CA5);
    bd = done_cnt; bq = svq.size();
    sv_ready = 1'b0;
    @(negedge clk) start_save = 1'b1;
    @(negedge clk) start_save = 1'b0;
    for (int c = 0; c < 50 && !sv_valid; c++) @(negedge clk);
    sv_ready = 1'b1;
    @(negedge clk) sv_ready = 1'b0;
    for (int c = 0; c < 50 && !sv_valid; c++) #10;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!(sv_valid && sv_dat == 8'h3C && ss_addr == 8'h01 && ss_act)) bad++;
    end
    check("stall_hold", 32'(bad), 32'd0);
    check("stall_len", 32'(svq.size() - bq), 32'd1);
    run_save(cyc);
    check("stall_stream", stream_at(bq), 32'h39073CA5);
    check("stall_done", 32'(done_cnt - bd), 32'd1);

    // Simultaneous starts, then a stray start mid-save.
    set_model(32'h12345678);
    bd = done_cnt; be = err_cnt; bw = we_cycles; bq = svq.size();
    sv_ready = 1'b1;
    @(negedge clk);
    start_save = 1'b1; start_load = 1'b1; ld_valid = 1'b1; ld_dat = 8'h12;
    @(negedge clk);
    start_save = 1'b0; start_load = 1'b0;
    repeat (3) @(negedge clk);
    start_load = 1'b1; start_save = 1'b1;
    @(negedge clk);
    start_load = 1'b0; start_save = 1'b0;
    for (int c = 0; c < 100 && done_cnt == bd; c++) @(negedge clk);
    ld_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("both_stream", stream_at(bq), 32'h12345678);
    check("both_len", 32'(svq.size() - bq), 32'd4);
    check("both_no_we", 32'(we_cycles - bw), 32'd0);
    check("both_one_done", 32'(done_cnt - bd + err_cnt - be), 32'd1);
    check("both_idle", 32'(busy), 32'd0);

    // Reset while the first write is in its m2-low phase.
    set_model(32'h39073CA5);
    run_load(32'h33221139, 1'b1, cyc);
    check("rst_in_fall", {31'h0, ss_m2}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async", {28'h0, ss_act, ss_m2, busy, ss_we}, 32'h4);
    ld_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    bd = done_cnt; bq = svq.size();
    run_save(cyc);
    check("rst_save_stream", stream_at(bq), 32'h39073C11);
    check("rst_save_done", 32'(done_cnt - bd), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
